// File: rtl/knight_seq_if.sv
// Configuration bus for knight_seq: one-cycle write strobe plus period/wrap payload.
interface knight_seq_if #(parameter int PRE_W = 16);
   logic             cfg_valid;
   logic [PRE_W-1:0] cfg_period;
   logic             cfg_wrap;
   logic             cfg_ready;

   modport master (output cfg_valid, cfg_period, cfg_wrap, input cfg_ready);
   modport slave  (input cfg_valid, cfg_period, cfg_wrap, output cfg_ready);
endinterface

// File: rtl/knight_seq.sv
// Knight flasher step sequencer: one-hot lamp scan with bounce/wrap, run/stop and
// shadowed config. Optional end-lamp dwell is enabled with `define KNIGHT_DWELL_EN.
module knight_seq #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 16,
   parameter int DWELL = 8
) (
   input  logic             ck,
   input  logic             res,
   input  logic             run,
   knight_seq_if.slave      cfg,
   output logic [WIDTH-1:0] out,
   output logic             up,
   output logic             step,
   output logic             end_pulse,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN
`ifdef KNIGHT_DWELL_EN
      , ST_DWELL
`endif
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] cnt;
   logic [PRE_W-1:0] period_r;
   logic             wrap_r;
   logic [PRE_W-1:0] shadow_period;
   logic             shadow_wrap;
   logic             pending;

   logic [PRE_W-1:0] nxt_period;
   logic             nxt_wrap;
   logic [WIDTH-1:0] next_out;
   logic             next_up;
   logic             go_up;
   logic             land_end;

   assign cfg.cfg_ready = 1'b1;

   // Config that becomes active at the next load point; a same-cycle write wins over the shadow.
   assign nxt_period = cfg.cfg_valid ? cfg.cfg_period : (pending ? shadow_period : period_r);
   assign nxt_wrap   = cfg.cfg_valid ? cfg.cfg_wrap   : (pending ? shadow_wrap   : wrap_r);

   // The step edge moves in the mode being loaded, so a wrap request takes effect on that step.
   always_comb begin
      next_out = out;
      next_up  = up;
      go_up    = up;
      if (nxt_wrap) begin
         next_out = out[WIDTH-1] ? ONE : (out << 1);
         next_up  = 1'b1;
      end else begin
         go_up    = out[WIDTH-1] ? 1'b0 : (out[0] ? 1'b1 : up);
         next_out = go_up ? (out << 1) : (out >> 1);
         next_up  = next_out[WIDTH-1] ? 1'b0 : (next_out[0] ? 1'b1 : go_up);
      end
   end

   assign land_end = next_out[0] | next_out[WIDTH-1];

`ifdef KNIGHT_DWELL_EN
   localparam logic [PRE_W-1:0] DWELL_LAST = PRE_W'(DWELL - 1);
   logic dwell_hit;
   assign dwell_hit = nxt_wrap ? next_out[WIDTH-1] : land_end;
`else
   logic unused_dwell;
   assign unused_dwell = ^DWELL;
`endif

   always_ff @(posedge ck or posedge res) begin
      if (res) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         period_r      <= PRE_W'(3);
         wrap_r        <= 1'b0;
         shadow_period <= '0;
         shadow_wrap   <= 1'b0;
         pending       <= 1'b0;
         out           <= ONE;
         up            <= 1'b1;
         step          <= 1'b0;
         end_pulse     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         step      <= 1'b0;
         end_pulse <= 1'b0;
         if (cfg.cfg_valid) begin
            shadow_period <= cfg.cfg_period;
            shadow_wrap   <= cfg.cfg_wrap;
            pending       <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               cnt      <= '0;
               period_r <= nxt_period;
               wrap_r   <= nxt_wrap;
               pending  <= 1'b0;
               if (run) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (cnt == period_r) begin
                  cnt       <= '0;
                  out       <= next_out;
                  up        <= next_up;
                  step      <= 1'b1;
                  end_pulse <= land_end;
                  period_r  <= nxt_period;
                  wrap_r    <= nxt_wrap;
                  pending   <= 1'b0;
                  if (!run) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
`ifdef KNIGHT_DWELL_EN
                  else if (dwell_hit) begin
                     state <= ST_DWELL;
                  end
`endif
               end else if (!run) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef KNIGHT_DWELL_EN
            ST_DWELL: begin
               if (!run) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == DWELL_LAST) begin
                  state    <= ST_RUN;
                  cnt      <= '0;
                  period_r <= nxt_period;
                  wrap_r   <= nxt_wrap;
                  pending  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/knight_seq.md
# knight_seq

Step sequencer for the 8-lamp knight flasher bar. Generates the lit-lamp pattern and scan direction from a programmable step prescaler, bounces (or wraps) at the bar ends, and supports run/stop with position retained. It sits between the board control registers and the lamp drivers, replacing the free-running bar with a configurable, start/stop-able scan.

## Interface
Parameters:
- WIDTH, 8, number of lamps (>= 2)
- PRE_W, 16, prescaler/period width
- DWELL, 8, hold cycles at an end lamp (used only with KNIGHT_DWELL_EN)

Ports:
- ck  in  1  clock, rising edge
- res  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = scan, 0 = stop and hold position
- cfg_valid  in  1  config write strobe, one cycle
- cfg_period  in  PRE_W  step interval minus one
- cfg_wrap  in  1  0 = bounce, 1 = wrap MSB->LSB
- cfg_ready  out  1  always 1 (config never stalls)
- out  out  WIDTH  one-hot lamp pattern
- up  out  1  current direction, 1 = toward MSB
- step  out  1  one-cycle pulse on each pattern change
- end_pulse  out  1  one-cycle pulse when pattern lands on out[0] or out[WIDTH-1]
- busy  out  1  1 when state != IDLE

## Operation
- Reset values: out = 1 (lamp 0), up = 1, step = 0, end_pulse = 0, busy = 0, state IDLE, cnt = 0, period_r = 3, wrap_r = 0, pending shadow cleared.
- States: IDLE, RUN, DWELL (DWELL exists only with KNIGHT_DWELL_EN).
- IDLE: cnt held at 0; run=1 -> RUN next edge.
- RUN: cnt increments each cycle; at cnt == period_r: cnt <= 0, step = 1, pattern shifts. Interval = period_r+1 cycles.
- Shift, bounce (wrap_r=0): up=1 -> out <= out<<1; up=0 -> out >> 1. When the new pattern is bit WIDTH-1, up <= 0 on the same edge; when bit 0, up <= 1.
- Shift, wrap (wrap_r=1): always moves toward MSB; from bit WIDTH-1 next step gives bit 0; up <= 1 on the first wrap step if it was 0.
- end_pulse asserts with the step that produces bit 0 or bit WIDTH-1.
- run=0 in RUN or DWELL -> IDLE next edge; out and up hold; cnt cleared. Resume continues from held position/direction.
- Config: cfg_valid writes shadow {cfg_period, cfg_wrap}. Active period_r/wrap_r load from shadow while IDLE (every cycle) or on a step edge in RUN. cfg_valid on the same cycle as a step edge loads the incoming values directly for the next interval.
- out is always exactly one-hot; no illegal pattern reachable.

## Timing
- step, end_pulse: registered, high the cycle after the edge where cnt==period_r was seen, coincident with new out.
- First step after run rises in IDLE: run sampled at edge E0 (-> RUN), step visible period_r+1 cycles later.
- period_r = 0: step every cycle in RUN.
- run falling same cycle as cnt==period_r: the step still completes, then IDLE.
- res mid-scan: immediate return to reset values, regardless of state.

## Configuration
- KNIGHT_DWELL_EN defined: on a step landing on an end lamp, RUN -> DWELL; hold DWELL cycles (cnt counts 0..DWELL-1), no steps; then RUN with cnt = 0. Wrap mode dwells at MSB only. Config shadow applies on DWELL exit.
- Not defined: no DWELL state; end lamps are held exactly one interval like any other.

## Test plan
- Reset then run=1, period 3, bounce: out 0x01,0x02,...,0x80,0x40,...,0x01 with steps every 4 cycles; up falls with 0x80, rises with 0x01; end_pulse at 0x80 and 0x01 only.
- run=0 at out=0x10, up=0 for 20 cycles -> out stays 0x10, busy=0; run=1 -> next step gives 0x08.
- cfg_wrap=1 while running at 0x20 up=0 -> next step 0x40, up=1; after 0x80 next step 0x01.
- period 0 -> step every cycle; cfg_valid period=9 coincident with a step edge -> next step exactly 10 cycles later.
- Assert res during step pulse at out=0x40 -> out=0x01, up=1, busy=0 without waiting for ck.
- KNIGHT_DWELL_EN, DWELL=8, period 1: on reaching 0x80 no step for 8 cycles, then 0x40 two cycles after DWELL exit.
